// File: rtl/cache_bus2_master.sv
// Cache-side bus2 master: one whole-line READ_LINE/WRITE_LINE at a time on A2/D2/C2, then data/status back to the core.
// Latency write BEATS+R+2, read 1+R+BEATS+1; req_ready only in IDLE (no queueing), next accept 2 cycles after rsp_valid.
module cache_bus2_master #(
  parameter int ADDR2_BUS_SIZE  = 14,
  parameter int DATA_BUS_SIZE   = 16,
  parameter int CTR2_BUS_SIZE   = 2,
  parameter int CACHE_LINE_SIZE = 16,
  parameter int RESP_TIMEOUT    = 255
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR2_BUS_SIZE-1:0]    req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0] req_wdata,
  output logic                         rsp_valid,
  output logic                         rsp_err,
  output logic [CACHE_LINE_SIZE*8-1:0] rsp_rdata,
  inout  wire  [ADDR2_BUS_SIZE-1:0]    A2_WIRE,
  inout  wire  [DATA_BUS_SIZE-1:0]     D2_WIRE,
  inout  wire  [CTR2_BUS_SIZE-1:0]     C2_WIRE
);

  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam int BEATS  = LINE_W / DATA_BUS_SIZE;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int TO_W   = $clog2(RESP_TIMEOUT + 1);

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_W_DATA, S_WAIT_RSP, S_R_DATA, S_DONE, S_TURN
  } state_t;

  typedef struct packed {
    logic                      write;
    logic [ADDR2_BUS_SIZE-1:0] addr;
    logic [LINE_W-1:0]         line;
  } req_t;

  state_t                   state, state_nxt;
  req_t                     req_q;
  logic [CNT_W-1:0]         cnt;
  logic [TO_W-1:0]          tmo;
  logic                     err;
  logic                     resp_seen, last_beat, tmo_last;
  logic [LINE_W-1:0]        line_cap;
  logic                     c2_oe, a2_oe, d2_oe;
  logic [CTR2_BUS_SIZE-1:0] c2_out;

  // Case-equality so a floating or contended C2 never reads as a response.
  assign resp_seen = (C2_WIRE === C2_RESPONSE);
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign tmo_last  = (tmo == TO_W'(RESP_TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (req_valid && req_ready) state_nxt = S_CMD;
      S_CMD:      state_nxt = req_q.write ? S_W_DATA : S_WAIT_RSP;
      S_W_DATA:   if (last_beat) state_nxt = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (resp_seen)     state_nxt = req_q.write ? S_DONE : S_R_DATA;
        else if (tmo_last) state_nxt = S_DONE;
      end
      S_R_DATA:   if (last_beat) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_TURN;
      S_TURN:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    c2_oe     = 1'b0;
    c2_out    = C2_NOP;
    a2_oe     = 1'b0;
    d2_oe     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = !RESET;
        c2_oe     = 1'b1;
      end
      S_CMD: begin
        c2_oe  = 1'b1;
        a2_oe  = 1'b1;
        c2_out = req_q.write ? C2_WRITE_LINE : C2_READ_LINE;
        d2_oe  = req_q.write;
      end
      S_W_DATA: begin
        c2_oe  = 1'b1;
        a2_oe  = 1'b1;
        c2_out = C2_WRITE_LINE;
        d2_oe  = 1'b1;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = err;
      end
      default: ;
    endcase
  end

  // Current read line with the beat on D2 merged in at the beat counter.
  always_comb begin
    line_cap = req_q.line;
    line_cap[cnt*DATA_BUS_SIZE +: DATA_BUS_SIZE] = D2_WIRE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      req_q     <= '0;
      cnt       <= '0;
      tmo       <= '0;
      err       <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_q.write <= req_write;
            req_q.addr  <= req_addr;
            req_q.line  <= req_wdata;
            cnt         <= '0;
            err         <= 1'b0;
          end
        end
        S_CMD: begin
          tmo <= '0;
          if (req_q.write) cnt <= CNT_W'(1);
        end
        S_W_DATA: begin
          tmo <= '0;
          cnt <= cnt + 1'b1;
        end
        S_WAIT_RSP: begin
          tmo <= tmo + 1'b1;
          if (resp_seen) begin
            if (!req_q.write) begin
              req_q.line[DATA_BUS_SIZE-1:0] <= D2_WIRE;
              cnt <= CNT_W'(1);
            end
          end else if (tmo_last) begin
            err <= 1'b1;
          end
        end
        S_R_DATA: begin
          req_q.line <= line_cap;
          cnt        <= cnt + 1'b1;
          if (last_beat) rsp_rdata <= line_cap;
        end
        default: ;
      endcase
    end
  end

  assign C2_WIRE = c2_oe ? c2_out : {CTR2_BUS_SIZE{1'bz}};
  assign A2_WIRE = a2_oe ? req_q.addr : {ADDR2_BUS_SIZE{1'bz}};
  assign D2_WIRE = d2_oe ? req_q.line[cnt*DATA_BUS_SIZE +: DATA_BUS_SIZE] : {DATA_BUS_SIZE{1'bz}};

endmodule

// File: tb/tb_cache_bus2_master.sv
// Directed bench for cache_bus2_master; bus nets are pulled up so a released bus reads all ones.
module tb_cache_bus2_master;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [13:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         req_ready, rsp_valid, rsp_err;
  logic [127:0] rsp_rdata;

  tri1 [13:0] A2_WIRE;
  tri1 [15:0] D2_WIRE;
  tri1 [1:0]  C2_WIRE;

  logic        mem_c2_oe = 1'b0;
  logic [1:0]  mem_c2 = 2'd1;
  logic        mem_d2_oe = 1'b0;
  logic [15:0] mem_d2 = '0;

  assign C2_WIRE = mem_c2_oe ? mem_c2 : 2'bzz;
  assign D2_WIRE = mem_d2_oe ? mem_d2 : 16'hzzzz;

  int vectors = 0;
  int miscompares = 0;

  cache_bus2_master dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .A2_WIRE(A2_WIRE), .D2_WIRE(D2_WIRE), .C2_WIRE(C2_WIRE)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte i of the line is base+i.
  function automatic logic [127:0] mk_line(input logic [7:0] base);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = base + 8'(i);
    return l;
  endfunction

  function automatic logic [15:0] beat_of(input logic [127:0] l, input int k);
    return l[16*k +: 16];
  endfunction

  // Presents one request in IDLE and plays the memory side; returns the cycle (1 = CMD) of rsp_valid, or -1.
  task automatic run_txn(input logic wr, input logic [13:0] addr, input logic [127:0] line,
                         input int r, input logic nv, input logic [13:0] naddr,
                         input logic [127:0] nline, output int rsp_cyc);
    int cyc, went, rsp_at;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = line;
    #1;
    chk("req_ready_idle", 128'(req_ready), 128'(1));
    step();
    req_valid = nv; req_addr = naddr; req_wdata = nline;
    cyc = 1;
    went = wr ? 9 : 2;
    rsp_at = (r >= 0) ? went + r : -1;
    rsp_cyc = -1;
    while (cyc < 400) begin
      mem_c2_oe = (cyc == rsp_at);
      mem_d2_oe = !wr && (rsp_at >= 0) && (cyc >= rsp_at) && (cyc < rsp_at + 8);
      if (mem_d2_oe) mem_d2 = beat_of(line, cyc - rsp_at);
      #1;
      if (wr && cyc <= 8) begin
        chk("wr_c2", 128'(C2_WIRE), 128'(3));
        chk("wr_a2", 128'(A2_WIRE), 128'(addr));
        chk("wr_d2", 128'(D2_WIRE), 128'(beat_of(line, cyc - 1)));
      end
      if (!wr && cyc == 1) begin
        chk("rd_c2_cmd", 128'(C2_WIRE), 128'(2));
        chk("rd_a2_cmd", 128'(A2_WIRE), 128'(addr));
        chk("rd_d2_cmd_released", 128'(D2_WIRE), 128'(16'hFFFF));
      end
      if (cyc == went) begin
        chk("wait_c2", 128'(C2_WIRE), (rsp_at == went) ? 128'(1) : 128'(3));
        chk("wait_a2_released", 128'(A2_WIRE), 128'(14'h3FFF));
      end
      if (rsp_valid) begin
        rsp_cyc = cyc;
        break;
      end
      step();
      cyc++;
    end
    mem_c2_oe = 1'b0;
    mem_d2_oe = 1'b0;
    #1;
  endtask

  // Checks DONE outputs, then TURN and the return to IDLE.
  task automatic finish_txn(input logic exp_err, input logic [127:0] exp_rdata);
    chk("done_err", 128'(rsp_err), 128'(exp_err));
    chk("done_rdata", rsp_rdata, exp_rdata);
    chk("done_a2_released", 128'(A2_WIRE), 128'(14'h3FFF));
    chk("done_d2_released", 128'(D2_WIRE), 128'(16'hFFFF));
    chk("done_c2_released", 128'(C2_WIRE), 128'(3));
    step();
    chk("turn_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("turn_req_ready", 128'(req_ready), 128'(0));
    chk("turn_c2_released", 128'(C2_WIRE), 128'(3));
    step();
    chk("idle_c2_nop", 128'(C2_WIRE), 128'(0));
    chk("idle_req_ready", 128'(req_ready), 128'(1));
    chk("idle_rdata_held", rsp_rdata, exp_rdata);
  endtask

  initial begin
    int lat;
    logic [127:0] wline, rline, l40, l60, l80, la0;
    wline = mk_line(8'h00);
    rline = mk_line(8'h10);
    l40   = mk_line(8'h40);
    l60   = mk_line(8'h60);
    l80   = mk_line(8'h80);
    la0   = mk_line(8'hA0);

    // Power-on reset
    step();
    step();
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_err", 128'(rsp_err), 128'(0));
    chk("rst_rdata", rsp_rdata, 128'(0));
    chk("rst_c2", 128'(C2_WIRE), 128'(0));
    chk("rst_a2_released", 128'(A2_WIRE), 128'(14'h3FFF));
    chk("rst_d2_released", 128'(D2_WIRE), 128'(16'hFFFF));
    RESET = 1'b0;
    step();
    chk("post_rst_req_ready", 128'(req_ready), 128'(1));

    // Reset pulse of 2 cycles while idle
    RESET = 1'b1;
    #1;
    chk("idle_rst_req_ready0", 128'(req_ready), 128'(0));
    step();
    chk("idle_rst_rsp_valid0", 128'(rsp_valid), 128'(0));
    step();
    chk("idle_rst_req_ready1", 128'(req_ready), 128'(0));
    chk("idle_rst_c2", 128'(C2_WIRE), 128'(0));
    RESET = 1'b0;
    step();

    // Write line, response 4 cycles into WAIT_RSP
    run_txn(1'b1, 14'h0A5, wline, 4, 1'b0, '0, '0, lat);
    chk("wr_latency", 128'(lat), 128'(14));
    finish_txn(1'b0, 128'(0));

    // Read line, response 3 cycles into WAIT_RSP
    run_txn(1'b0, 14'h3FF, rline, 3, 1'b0, '0, '0, lat);
    chk("rd_latency", 128'(lat), 128'(13));
    chk("rd_rdata_const", rsp_rdata, 128'h1F1E1D1C1B1A19181716151413121110);
    finish_txn(1'b0, rline);

    // Read with no response: timeout
    run_txn(1'b0, 14'h012, l40, -1, 1'b0, '0, '0, lat);
    chk("tmo_latency", 128'(lat), 128'(257));
    finish_txn(1'b1, rline);

    // Reset during W_DATA beat 3
    req_valid = 1'b1; req_write = 1'b1; req_addr = 14'h123; req_wdata = l60;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    chk("abort_beat3_d2", 128'(D2_WIRE), 128'(16'h0706 + 16'h6060));
    RESET = 1'b1;
    step();
    chk("abort_c2_nop", 128'(C2_WIRE), 128'(0));
    chk("abort_a2_released", 128'(A2_WIRE), 128'(14'h3FFF));
    chk("abort_d2_released", 128'(D2_WIRE), 128'(16'hFFFF));
    chk("abort_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("abort_rdata_cleared", rsp_rdata, 128'(0));
    RESET = 1'b0;
    step();
    chk("abort_idle_ready", 128'(req_ready), 128'(1));

    // Read after the abort, response in the first WAIT_RSP cycle
    run_txn(1'b0, 14'h001, l40, 0, 1'b0, '0, '0, lat);
    chk("rd_r0_latency", 128'(lat), 128'(10));
    finish_txn(1'b0, l40);

    // Back-to-back writes with req_valid held
    run_txn(1'b1, 14'h2AA, l80, 0, 1'b1, 14'h155, la0, lat);
    chk("b2b_first_latency", 128'(lat), 128'(10));
    finish_txn(1'b0, l40);
    run_txn(1'b1, 14'h155, la0, 2, 1'b0, '0, '0, lat);
    chk("b2b_second_latency", 128'(lat), 128'(12));
    finish_txn(1'b0, l40);
    step();
    chk("b2b_no_dup_c2", 128'(C2_WIRE), 128'(0));
    chk("b2b_no_dup_ready", 128'(req_ready), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule

// File: doc/cache_bus2_master.md
Name: cache_bus2_master

Overview:
- Bus2 master on the cache side, directly upstream of the memory controller.
- Accepts whole-line read and write requests from the cache core.
- Drives command, address and data on A2/D2/C2, then hands the bus to the memory controller and waits for C2_RESPONSE.
- Returns read-line data, or a completion/timeout status, to the cache core.

Parameters:
- ADDR2_BUS_SIZE, 14: line address width (tag+set).
- DATA_BUS_SIZE, 16: D2 width; two bytes per beat, low byte = lower address.
- CTR2_BUS_SIZE, 2: C2 width.
- CACHE_LINE_SIZE, 16: bytes per line; BEATS = CACHE_LINE_SIZE*8/DATA_BUS_SIZE = 8.
- RESP_TIMEOUT, 255: max cycles in WAIT_RSP before error.
- C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3: command encodings.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  cache core presents a request.
- req_ready  out  1  master can accept a request.
- req_write  in  1  1 = WRITE_LINE, 0 = READ_LINE.
- req_addr  in  ADDR2_BUS_SIZE  line address.
- req_wdata  in  CACHE_LINE_SIZE*8  write line; byte i = bits [8i+7:8i].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid; 1 = timeout.
- rsp_rdata  out  CACHE_LINE_SIZE*8  read line; held until next rsp_valid.
- A2_WIRE  inout  ADDR2_BUS_SIZE  bus2 address.
- D2_WIRE  inout  DATA_BUS_SIZE  bus2 data.
- C2_WIRE  inout  CTR2_BUS_SIZE  bus2 command.

Behaviour:
- Reset, in the cycle after a RESET edge:
  - state = IDLE; req_ready = 0 during any cycle RESET is high; rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - C2 driven C2_NOP; A2 and D2 high-Z.
  - Reset mid-operation aborts immediately: no rsp_valid, bus returns to IDLE ownership next cycle, captured data discarded.
- Ownership:
  - Master owns C2 in IDLE, CMD and W_DATA.
  - In WAIT_RSP, R_DATA and TURN, all three buses are high-Z.
  - C2 is released/retaken only on state changes at posedge.
- States:
  - IDLE: req_ready = 1; C2 = NOP. On req_valid && req_ready, latch addr, write flag and wdata; go to CMD.
  - CMD (1 cycle): A2 = latched addr.
    - Write: C2 = WRITE_LINE, D2 = beat 0 (bytes 1:0); go to W_DATA with beat counter = 1.
    - Read: C2 = READ_LINE, D2 high-Z; go to WAIT_RSP.
  - W_DATA: C2 = WRITE_LINE, A2 held, D2 = beat[cnt]; cnt increments each cycle. After beat BEATS-1 is driven, go to WAIT_RSP. A write occupies exactly BEATS cycles of bus drive, CMD included.
  - WAIT_RSP:
    - Timeout counter clears on entry and increments each cycle.
    - C2_WIRE sampled with case-equality; Z/X counts as no response.
    - C2_WIRE === C2_RESPONSE, write: go to DONE.
    - C2_WIRE === C2_RESPONSE, read: capture D2 as beat 0 in that same cycle; go to R_DATA with cnt = 1.
    - Counter reaching RESP_TIMEOUT with no response: go to DONE with err = 1.
  - R_DATA: capture D2 into beat[cnt] every cycle regardless of C2. After beat BEATS-1, go to DONE.
  - DONE (1 cycle): rsp_valid = 1, rsp_err = err; rsp_rdata updated only on a successful read. Bus high-Z. Go to TURN.
  - TURN (1 cycle): bus high-Z for turnaround; go to IDLE, which resumes driving C2_NOP.
- req_ready = 1 only in IDLE; requests are never queued.
- Latency from acceptance edge to rsp_valid, with memory asserting C2_RESPONSE R cycles after entering WAIT_RSP:
  - Write: BEATS + R + 2.
  - Read: 1 + R + BEATS + 1.
  - Next request is accepted 2 cycles after rsp_valid.
- C2_RESPONSE seen in the first WAIT_RSP cycle (R = 0) is legal.
- A C2_RESPONSE seen in any state other than WAIT_RSP is ignored.

Test Plan:
- Reset: RESET high 2 cycles mid-idle -> C2_WIRE = 0, A2/D2 = Z, req_ready = 0 while high, rsp_valid never asserted.
- Write line: addr = 14'h0A5, wdata bytes = 0x00..0x0F; memory model responds R = 4 -> C2 = 3 for 8 cycles, A2 = 0x0A5, D2 sequence 0x0100, 0x0302, ..., 0x0F0E; bus Z; rsp_valid at cycle 14 with rsp_err = 0.
- Read line: addr = 14'h3FF; model responds R = 3, supplying D2 = 0x1110, 0x1312, ..., 0x1F1E -> C2 = 2 for exactly 1 cycle; rsp_rdata bytes 0x10..0x1F; rsp_valid at cycle 13.
- Timeout: read with no response -> rsp_valid with rsp_err = 1 after 1 + 255 + 1 cycles; rsp_rdata unchanged; IDLE resumes with C2 = 0.
- Reset mid-W_DATA: assert RESET at beat 3 -> next cycle C2 = NOP, A2/D2 = Z, no rsp_valid; a following read completes normally.
- Back-to-back: req_valid held high with two writes -> second accepted exactly 2 cycles after first rsp_valid; no request lost or duplicated.
